// File: rtl/axil_led_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite LED register block.
package axil_led_pkg;

   // Byte offsets of the four registers; only ADDR[3:2] takes part in decoding.
   localparam logic [3:0] OFF_LED_VAL = 4'h0;
   localparam logic [3:0] OFF_CTRL    = 4'h4;
   localparam logic [3:0] OFF_PERIOD  = 4'h8;
   localparam logic [3:0] OFF_SCRATCH = 4'hC;

   // CTRL bit that enables the blink engine.
   localparam int unsigned CTRL_EN_BIT = 0;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   // Word index of a register offset.
   function automatic logic [1:0] reg_idx(input logic [3:0] off);
      return off[3:2];
   endfunction

   localparam logic [1:0] IDX_LED_VAL = reg_idx(OFF_LED_VAL);
   localparam logic [1:0] IDX_CTRL    = reg_idx(OFF_CTRL);
   localparam logic [1:0] IDX_PERIOD  = reg_idx(OFF_PERIOD);
   localparam logic [1:0] IDX_SCRATCH = reg_idx(OFF_SCRATCH);

   // Merge new_val into old_val one byte lane per strobe bit.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/led_blink.sv
// Blink engine: free-running period counter with a phase bit gating the LED pattern.
module led_blink #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [31:0]      period,
   input  logic             restart,
   input  logic [Width-1:0] led_val,
   output logic [Width-1:0] led
);

   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      last;
   logic             phase_q, phase_d;
   logic [Width-1:0] led_q, led_d;

   // Next counter/phase; a period of 0 wraps every clock just like 1.
   always_comb begin
      last    = (period == 32'd0) ? 32'd0 : period - 32'd1;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      led_d   = led_val & {Width{phase_q}};
      if (restart || !enable) begin
         cnt_d   = 32'd0;
         phase_d = 1'b1;
      end else if (cnt_q >= last) begin
         cnt_d   = 32'd0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Engine state and registered LED drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= 32'd0;
         phase_q <= 1'b1;
         led_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         led_q   <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/axil_led_regs.sv
// AXI4-Lite slave with four 32-bit registers driving a blinking LED bank.
module axil_led_regs
   import axil_led_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int LED_WIDTH          = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [LED_WIDTH-1:0]            LED
);

   // Held low until the first edge after reset release so no ready rises asynchronously.
   logic        rst_done_q, rst_done_d;
   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic        aw_full_q, aw_full_d;
   logic [1:0]  aw_idx_q, aw_idx_d;
   logic        w_full_q, w_full_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        bvalid_q, bvalid_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] led_val_q, led_val_d, ctrl_q, ctrl_d, period_q, period_d, scratch_q, scratch_d;

   logic        aw_hs, w_hs, ar_hs, wr_commit, cfg_write;
   logic [1:0]  wr_idx;
   logic [31:0] wr_data, rd_val;
   logic [3:0]  wr_strb;
   logic        unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = rst_done_q & (w_state_q == W_IDLE) & ~aw_full_q;
   assign S_AXI_WREADY  = rst_done_q & (w_state_q == W_IDLE) & ~w_full_q;
   assign S_AXI_ARREADY = rst_done_q & (r_state_q == R_IDLE);
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

   // Write channel: latch AW/W independently, commit once both are present.
   always_comb begin
      rst_done_d = 1'b1;
      aw_hs      = S_AXI_AWVALID & S_AXI_AWREADY;
      w_hs       = S_AXI_WVALID & S_AXI_WREADY;
      wr_idx     = aw_full_q ? aw_idx_q : S_AXI_AWADDR[3:2];
      wr_data    = w_full_q ? w_data_q : S_AXI_WDATA;
      wr_strb    = w_full_q ? w_strb_q : S_AXI_WSTRB;
      wr_commit  = (w_state_q == W_IDLE) & (aw_full_q | aw_hs) & (w_full_q | w_hs);
      cfg_write  = wr_commit & ((wr_idx == IDX_CTRL) | (wr_idx == IDX_PERIOD));
      w_state_d  = w_state_q;
      aw_full_d  = aw_full_q;
      aw_idx_d   = aw_idx_q;
      w_full_d   = w_full_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      bvalid_d   = bvalid_q;
      led_val_d  = led_val_q;
      ctrl_d     = ctrl_q;
      period_d   = period_q;
      scratch_d  = scratch_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (wr_commit) begin
               case (wr_idx)
                  IDX_LED_VAL: led_val_d = apply_strb(led_val_q, wr_data, wr_strb);
                  IDX_CTRL:    ctrl_d    = apply_strb(ctrl_q, wr_data, wr_strb);
                  IDX_PERIOD:  period_d  = apply_strb(period_q, wr_data, wr_strb);
                  IDX_SCRATCH: scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
                  default: ;
               endcase
               aw_full_d = 1'b0;
               w_full_d  = 1'b0;
               bvalid_d  = 1'b1;
               w_state_d = W_RESP;
            end else begin
               if (aw_hs) begin
                  aw_full_d = 1'b1;
                  aw_idx_d  = S_AXI_AWADDR[3:2];
               end
               if (w_hs) begin
                  w_full_d = 1'b1;
                  w_data_d = S_AXI_WDATA;
                  w_strb_d = S_AXI_WSTRB;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               bvalid_d  = 1'b0;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: capture the addressed register on AR, hold until RREADY.
   always_comb begin
      ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      case (S_AXI_ARADDR[3:2])
         IDX_LED_VAL: rd_val = led_val_q;
         IDX_CTRL:    rd_val = ctrl_q;
         IDX_PERIOD:  rd_val = period_q;
         IDX_SCRATCH: rd_val = scratch_q;
         default:     rd_val = 32'd0;
      endcase
      unique case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rdata_d   = rd_val;
               rvalid_d  = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               rvalid_d  = 1'b0;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // All bus-side state; reset discards any half-received write.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rst_done_q <= 1'b0;
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_full_q  <= 1'b0;
         aw_idx_q   <= 2'd0;
         w_full_q   <= 1'b0;
         w_data_q   <= 32'd0;
         w_strb_q   <= 4'd0;
         bvalid_q   <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         led_val_q  <= 32'd0;
         ctrl_q     <= 32'd0;
         period_q   <= 32'd0;
         scratch_q  <= 32'd0;
      end else begin
         rst_done_q <= rst_done_d;
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_full_q  <= aw_full_d;
         aw_idx_q   <= aw_idx_d;
         w_full_q   <= w_full_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         bvalid_q   <= bvalid_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         led_val_q  <= led_val_d;
         ctrl_q     <= ctrl_d;
         period_q   <= period_d;
         scratch_q  <= scratch_d;
      end
   end

   led_blink #(
      .Width (LED_WIDTH)
   ) u_blink (
      .clk     (ACLK),
      .rst_n   (ARESETN),
      .enable  (ctrl_q[CTRL_EN_BIT]),
      .period  (period_q),
      .restart (cfg_write),
      .led_val (led_val_q[LED_WIDTH-1:0]),
      .led     (LED)
   );

endmodule
